// File: rtl/led_p2s_serializer.sv
// Parallel-to-serial shift engine for chained LED driver shift registers.
// Shifts a WIDTH-bit word out on sdata/sclk, strobes latch, and captures the word returned on s_in.
module led_p2s_serializer #(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] p_data,
   input  logic             s_in,
   output logic             sdata,
   output logic             sclk,
   output logic             latch,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LATCH,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sdata_q, sdata_d;
   logic             sclk_q, sclk_d;
   logic             latch_q, latch_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;

   logic [WIDTH-1:0] shifted;
   logic             div_end;

   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shreg_q[WIDTH-2:0], s_in};
      end else begin
         shifted = {s_in, shreg_q[WIDTH-1:1]};
      end
      div_end = (div_q == DIV_LAST);
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sclk_d  = sclk_q;
      latch_d = latch_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      q_out_d = q_out_q;

      case (state_q)
         // DONE accepts start just like IDLE so transfers can run back to back
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_SHIFT_LO;
               shreg_d = p_data;
               cnt_d   = CNT_FULL;
               div_d   = '0;
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
            end
         end
         S_SHIFT_LO: begin
            if (div_end) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SHIFT_HI;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_SHIFT_HI: begin
            if (div_end) begin
               div_d   = '0;
               sclk_d  = 1'b0;
               shreg_d = shifted;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_LATCH;
                  latch_d = 1'b1;
                  q_out_d = shifted;
               end else begin
                  state_d = S_SHIFT_LO;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_LATCH: begin
            if (div_end) begin
               div_d   = '0;
               latch_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // sdata is registered so it tracks the output end of the next shreg value
      sdata_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         sdata_q <= 1'b0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         q_out_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sdata_q <= sdata_d;
         sclk_q  <= sclk_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         q_out_q <= q_out_d;
      end
   end

   assign sdata = sdata_q;
   assign sclk  = sclk_q;
   assign latch = latch_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign q_out = q_out_q;

endmodule

// File: tb/tb_led_p2s_serializer.sv
// Directed bench for led_p2s_serializer: an MSB-first and an LSB-first 8-bit instance,
// with a modelled external shift-register chain feeding s_in of the MSB-first one.
module tb_led_p2s_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, start_b;
   logic [7:0] p_data, p_data_b;
   logic       s_in, s_in_b;
   logic       sdata, sclk, latch, busy, done;
   logic       sdata_b, sclk_b, latch_b, busy_b, done_b;
   logic [7:0] q_out, q_out_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] chain;
   logic [7:0] chain_init;
   logic       chain_load;
   logic       sclk_prev;

   always #5 clk = ~clk;

   led_p2s_serializer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .start(start), .p_data(p_data), .s_in(s_in),
      .sdata(sdata), .sclk(sclk), .latch(latch), .busy(busy), .done(done), .q_out(q_out)
   );

   led_p2s_serializer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .start(start_b), .p_data(p_data_b), .s_in(s_in_b),
      .sdata(sdata_b), .sclk(sclk_b), .latch(latch_b), .busy(busy_b), .done(done_b), .q_out(q_out_b)
   );

   // External chain: its serial output is a flop that advances one bit per sclk rising edge
   always @(posedge clk) begin
      sclk_prev <= sclk;
      if (chain_load) begin
         chain <= chain_init;
      end else if (sclk && !sclk_prev) begin
         s_in  <= chain[7];
         chain <= {chain[6:0], 1'b0};
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit sel, input logic [7:0] data);
      @(negedge clk);
      if (sel) begin
         p_data_b = data;
         start_b  = 1'b1;
      end else begin
         p_data = data;
         start  = 1'b1;
      end
      @(negedge clk);
      start   = 1'b0;
      start_b = 1'b0;
   endtask

   // Watches one transfer from the cycle after the accepting edge up to and including done
   task automatic captureTransfer(input bit sel, input int poke_at, input bit chain_next,
                                  input logic [7:0] chain_data,
                                  output logic [7:0] seq, output int nbits, output int busy_cnt,
                                  output int latch_cnt, output logic [7:0] q_at_latch,
                                  output bit timing_ok, output bit done_ok);
      logic c_sclk, c_busy, c_latch, c_done, c_sdata;
      logic [7:0] c_q;
      logic prev_sclk = 1'b0, prev_busy = 1'b1, prev_latch = 1'b0;
      int run = 0;
      bit finished = 1'b0;
      seq = 8'h00; nbits = 0; busy_cnt = 0; latch_cnt = 0; q_at_latch = 8'h00;
      timing_ok = 1'b1; done_ok = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         c_sclk  = sel ? sclk_b  : sclk;
         c_busy  = sel ? busy_b  : busy;
         c_latch = sel ? latch_b : latch;
         c_done  = sel ? done_b  : done;
         c_sdata = sel ? sdata_b : sdata;
         c_q     = sel ? q_out_b : q_out;
         if (c_busy) busy_cnt++;
         if (c_latch) latch_cnt++;
         if (c_latch && !prev_latch) q_at_latch = c_q;
         if (c_sclk != prev_sclk) begin
            if (run != 2) timing_ok = 1'b0;
            run = 1;
            if (c_sclk) begin
               seq = {seq[6:0], c_sdata};
               nbits++;
            end
         end else begin
            run++;
         end
         if (!sel && cyc == poke_at) begin
            start  = 1'b1;
            p_data = 8'hFF;
         end else if (!sel && cyc == poke_at + 1) begin
            start = 1'b0;
         end
         if (c_done) begin
            finished = 1'b1;
            done_ok  = !c_busy && prev_busy;
            if (chain_next) begin
               start  = 1'b1;
               p_data = chain_data;
            end
         end
         prev_sclk  = c_sclk;
         prev_busy  = c_busy;
         prev_latch = c_latch;
         @(negedge clk);
      end
      start = 1'b0;
      if (!finished) checkOutput("transfer_timeout", 32'd1, 32'd0);
   endtask

   logic [7:0] seq, qlat;
   int         nb, bc, lc;
   bit         tok, dok;

   initial begin
      rst = 1'b1; start = 1'b1; start_b = 1'b1;
      p_data = 8'hFF; p_data_b = 8'hFF; s_in_b = 1'b1;
      chain_load = 1'b1; chain_init = 8'h00;

      repeat (3) @(negedge clk);
      checkOutput("rst_sdata", {31'd0, sdata}, 32'd0);
      checkOutput("rst_sclk",  {31'd0, sclk},  32'd0);
      checkOutput("rst_latch", {31'd0, latch}, 32'd0);
      checkOutput("rst_busy",  {31'd0, busy},  32'd0);
      checkOutput("rst_done",  {31'd0, done},  32'd0);
      checkOutput("rst_q_out", {24'd0, q_out}, 32'd0);
      checkOutput("rst_busy_b", {31'd0, busy_b}, 32'd0);
      rst = 1'b0; start = 1'b0; start_b = 1'b0; chain_load = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);

      $display("[TB] basic MSB-first send of 0xA5");
      applyStimulus(1'b0, 8'hA5);
      captureTransfer(1'b0, -1, 1'b0, 8'h00, seq, nb, bc, lc, qlat, tok, dok);
      checkOutput("basic_seq",    {24'd0, seq}, 32'hA5);
      checkOutput("basic_nbits",  nb, 32'd8);
      checkOutput("basic_busy",   bc, 32'd34);
      checkOutput("basic_latch",  lc, 32'd2);
      checkOutput("basic_timing", {31'd0, tok}, 32'd1);
      checkOutput("basic_done",   {31'd0, dok}, 32'd1);

      $display("[TB] LSB-first send of 0x3C with s_in tied high");
      applyStimulus(1'b1, 8'h3C);
      captureTransfer(1'b1, -1, 1'b0, 8'h00, seq, nb, bc, lc, qlat, tok, dok);
      checkOutput("lsb_seq",      {24'd0, seq}, 32'h3C);
      checkOutput("lsb_busy",     bc, 32'd34);
      checkOutput("lsb_q_latch",  {24'd0, qlat}, 32'hFF);
      repeat (3) @(negedge clk);
      checkOutput("lsb_q_held",   {24'd0, q_out_b}, 32'hFF);

      $display("[TB] loopback through chain preloaded with 0x5A");
      chain_init = 8'h5A; chain_load = 1'b1;
      @(negedge clk);
      chain_load = 1'b0;
      applyStimulus(1'b0, 8'hC3);
      captureTransfer(1'b0, -1, 1'b0, 8'h00, seq, nb, bc, lc, qlat, tok, dok);
      checkOutput("loop_seq",     {24'd0, seq}, 32'hC3);
      checkOutput("loop_q_latch", {24'd0, qlat}, 32'h5A);
      checkOutput("loop_q_out",   {24'd0, q_out}, 32'h5A);

      $display("[TB] ignored mid-transfer start, then back-to-back");
      applyStimulus(1'b0, 8'h12);
      captureTransfer(1'b0, 10, 1'b1, 8'h34, seq, nb, bc, lc, qlat, tok, dok);
      checkOutput("ignore_seq",   {24'd0, seq}, 32'h12);
      checkOutput("ignore_busy",  bc, 32'd34);
      checkOutput("b2b_restart",  {31'd0, busy}, 32'd1);
      captureTransfer(1'b0, -1, 1'b0, 8'h00, seq, nb, bc, lc, qlat, tok, dok);
      checkOutput("b2b_seq",      {24'd0, seq}, 32'h34);
      checkOutput("b2b_busy",     bc, 32'd34);

      $display("[TB] reset after third sclk rise");
      applyStimulus(1'b0, 8'hA5);
      begin
         int  rises = 0;
         logic prv = 1'b0;
         bit  seen = 1'b0;
         for (int cyc = 0; cyc < 100 && rises < 3; cyc++) begin
            if (sclk && !prv) rises++;
            prv = sclk;
            if (rises < 3) @(negedge clk);
         end
         checkOutput("abort_rises", rises, 32'd3);
         rst = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("abort_sclk", {31'd0, sclk}, 32'd0);
         checkOutput("abort_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
         rst = 1'b0;
         for (int cyc = 0; cyc < 60; cyc++) begin
            if (latch || done) seen = 1'b1;
            @(negedge clk);
         end
         checkOutput("abort_no_latch_done", {31'd0, seen}, 32'd0);
         checkOutput("abort_q_out", {24'd0, q_out}, 32'd0);
         checkOutput("abort_idle",  {31'd0, busy}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
